dvp_frame_dma: RTL and testbench

- Write-sequencing controller for the DVP RX path. Moves packed pixel words from the RX pixel stream into system memory over an AXI4 master write port.
- Driven by the config block outputs: dvp_stat bit0 is the capture enable; pxl_mem_base is the frame buffer address.
- Splits each frame into fixed-length INCR bursts and tracks the write responses.
- Pulses frame-done and raises a sticky error flag for the CPU/status path.

---
 rtl/dvp_frame_dma_if.sv | 40 ++++
 rtl/dvp_frame_dma.sv | 194 +++++++++++++++++++
 tb/tb_dvp_frame_dma.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dvp_frame_dma_if.sv
// AXI4 write-channel bundle (AW/W/B) for dvp_frame_dma.
// The master modport is the DMA side; the slave modport is the memory side.
interface dvp_frame_dma_if #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int MST_ID_W         = 5,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_RESP_W     = 2
);
    logic [MST_ID_W-1:0]         m_awid_o;
    logic [ADDR_W-1:0]           m_awaddr_o;
    logic [TRANS_DATA_LEN_W-1:0] m_awlen_o;
    logic                        m_awvalid_o;
    logic                        m_awready_i;
    logic [DATA_W-1:0]           m_wdata_o;
    logic                        m_wlast_o;
    logic                        m_wvalid_o;
    logic                        m_wready_i;
    logic [TRANS_RESP_W-1:0]     m_bresp_i;
    logic                        m_bvalid_i;
    logic                        m_bready_o;

    modport master (
        output m_awid_o, m_awaddr_o, m_awlen_o, m_awvalid_o,
        input  m_awready_i,
        output m_wdata_o, m_wlast_o, m_wvalid_o,
        input  m_wready_i,
        input  m_bresp_i, m_bvalid_i,
        output m_bready_o
    );

    modport slave (
        input  m_awid_o, m_awaddr_o, m_awlen_o, m_awvalid_o,
        output m_awready_i,
        input  m_wdata_o, m_wlast_o, m_wvalid_o,
        output m_wready_i,
        output m_bresp_i, m_bvalid_i,
        input  m_bready_o
    );
endinterface

// File: rtl/dvp_frame_dma.sv
// DVP RX frame DMA: splits each frame into fixed-length AXI4 INCR bursts,
// one outstanding at a time, and tracks write responses.
// Optional frame cycle counter enabled by macro DVP_FRAME_DMA_PERF_EN.
module dvp_frame_dma #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter int MST_ID_W         = 5,
    parameter int MST_ID           = 0,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_RESP_W     = 2,
    parameter int BURST_LEN        = 16,
    parameter int FRAME_WORDS      = 9600
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         dvp_stat_i,
    input  logic [ADDR_W-1:0]   pxl_mem_base_i,
    input  logic                frm_start_i,
    input  logic [DATA_W-1:0]   pxl_data_i,
    input  logic                pxl_vld_i,
    output logic                pxl_rdy_o,
    dvp_frame_dma_if.master     axi,
    output logic                frm_done_o,
    output logic                err_o,
    output logic [31:0]         frm_cycles_o
);
    localparam int MAX_W = (FRAME_WORDS > BURST_LEN) ? FRAME_WORDS : BURST_LEN;
    localparam int CNT_W = $clog2(MAX_W + 1) + 1;
    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_WORDS);
    localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST_LEN);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_FRM = 3'd1;
    localparam logic [2:0] ADDR     = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] RESP     = 3'd4;

    logic [2:0]                  state;
    logic [ADDR_W-1:0]           base;
    logic [ADDR_W-1:0]           awaddr;
    logic [TRANS_DATA_LEN_W-1:0] awlen;
    logic [TRANS_DATA_LEN_W-1:0] beat_cnt;
    logic [CNT_W-1:0]            word_cnt;
    logic [CNT_W-1:0]            next_cnt;
    logic [ADDR_W-1:0]           base_aligned;
    logic                        awvalid;
    logic                        bready;
    logic                        done;
    logic                        err;
    logic                        en;
    logic                        in_data;
    logic                        w_hs;
    logic                        wlast;
    logic                        unused_ok;

    // AWLEN for the burst starting at word cnt: remaining words capped at BURST_LEN
    function automatic logic [TRANS_DATA_LEN_W-1:0] len_of(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] rem;
        rem = FRAME_C - cnt;
        if (rem < BURST_C)
            len_of = TRANS_DATA_LEN_W'(rem - CNT_W'(1));
        else
            len_of = TRANS_DATA_LEN_W'(BURST_C - CNT_W'(1));
    endfunction

    // Byte address of word cnt within the frame buffer
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b,
                                                  input logic [CNT_W-1:0] cnt);
        addr_of = b + (ADDR_W'(cnt) << 2);
    endfunction

    assign en           = dvp_stat_i[0];
    assign base_aligned = {pxl_mem_base_i[ADDR_W-1:6], 6'b0};
    assign in_data      = (state == DATA);
    assign w_hs         = in_data & pxl_vld_i & axi.m_wready_i;
    assign wlast        = in_data & (beat_cnt == awlen);
    assign next_cnt     = word_cnt + CNT_W'(awlen) + CNT_W'(1);
    assign unused_ok    = ^{dvp_stat_i[31:1], pxl_mem_base_i[5:0]};

    // Write channel is a straight pass-through of the pixel stream, gated to DATA
    assign pxl_rdy_o      = in_data & axi.m_wready_i;
    assign axi.m_wvalid_o = in_data & pxl_vld_i;
    assign axi.m_wdata_o  = in_data ? pxl_data_i : '0;
    assign axi.m_wlast_o  = wlast;

    assign axi.m_awid_o    = MST_ID_W'(MST_ID);
    assign axi.m_awaddr_o  = awaddr;
    assign axi.m_awlen_o   = awlen;
    assign axi.m_awvalid_o = awvalid;
    assign axi.m_bready_o  = bready;
    assign frm_done_o      = done;
    assign err_o           = err;

    // Burst sequencer: one AW, its W beats, then its B before the next AW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            base     <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            awvalid  <= 1'b0;
            beat_cnt <= '0;
            word_cnt <= '0;
            bready   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) state <= WAIT_FRM;
                    else    err   <= 1'b0;
                end
                WAIT_FRM: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (frm_start_i) begin
                        base     <= base_aligned;
                        word_cnt <= '0;
                        awaddr   <= base_aligned;
                        awlen    <= len_of('0);
                        awvalid  <= 1'b1;
                        state    <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.m_awready_i) begin
                        awvalid  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (wlast) begin
                            bready <= 1'b1;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (axi.m_bvalid_i) begin
                        bready   <= 1'b0;
                        word_cnt <= next_cnt;
                        if (axi.m_bresp_i != '0) err <= 1'b1;
                        if (next_cnt >= FRAME_C) begin
                            done  <= 1'b1;
                            state <= en ? WAIT_FRM : IDLE;
                        end else if (en) begin
                            awaddr  <= addr_of(base, next_cnt);
                            awlen   <= len_of(next_cnt);
                            awvalid <= 1'b1;
                            state   <= ADDR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DVP_FRAME_DMA_PERF_EN
    logic [31:0] cyc_cnt;
    logic [31:0] cycles;
    logic        busy;

    assign busy         = (state == ADDR) || (state == DATA) || (state == RESP);
    assign frm_cycles_o = cycles;

    // Saturating busy-cycle counter, restarted by an accepted frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cyc_cnt <= '0;
        else if (state == WAIT_FRM && en && frm_start_i)
            cyc_cnt <= '0;
        else if (busy && cyc_cnt != '1)
            cyc_cnt <= cyc_cnt + 32'd1;
    end

    // Snapshot the count as the frame-done pulse is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycles <= '0;
        else if (done)
            cycles <= cyc_cnt;
    end
`else
    assign frm_cycles_o = '0;
`endif

endmodule

// File: tb/tb_dvp_frame_dma.sv
// Directed bench for dvp_frame_dma: FRAME_WORDS=40, BURST_LEN=16.
module tb_dvp_frame_dma;
    localparam int FW = 40;
    localparam int BL = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dvp_stat = '0;
    logic [31:0] base = '0;
    logic        frm_start = 1'b0;
    logic [31:0] pxl_data;
    logic        pxl_vld;
    logic        pxl_rdy;
    logic        frm_done;
    logic        err;
    logic [31:0] frm_cycles;

    int checks = 0;
    int failures = 0;

    // bus model state and logs
    int          cyc = 0;
    int          t_start = 0;
    int          t_b = 0;
    int          done_cnt = 0;
    int          b_cnt = 0;
    int          aw_wait = 0;
    int          aw_delay = 0;
    int          err_burst = -1;
    int          aw_unstable = 0;
    bit          rand_mode = 0;
    bit          b_pending = 0;
    bit          aw_hold = 0;
    bit          perf_nonzero = 0;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    logic [31:0] next_pix = 0;
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    bit          w_last_q[$];

    always #5 clk = ~clk;

    dvp_frame_dma_if #(.DATA_W(32), .ADDR_W(32), .MST_ID_W(5),
                       .TRANS_DATA_LEN_W(8), .TRANS_RESP_W(2)) axi ();

    dvp_frame_dma #(.FRAME_WORDS(FW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .dvp_stat_i(dvp_stat), .pxl_mem_base_i(base),
        .frm_start_i(frm_start), .pxl_data_i(pxl_data), .pxl_vld_i(pxl_vld),
        .pxl_rdy_o(pxl_rdy), .axi(axi), .frm_done_o(frm_done), .err_o(err),
        .frm_cycles_o(frm_cycles)
    );

    // Slave + pixel source + monitor: sample on negedge, drive 1 after posedge
    initial begin
        axi.m_awready_i = 1'b0;
        axi.m_wready_i  = 1'b0;
        axi.m_bvalid_i  = 1'b0;
        axi.m_bresp_i   = '0;
        pxl_vld  = 1'b0;
        pxl_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (frm_start) t_start = cyc;
            if (frm_done) done_cnt++;
            if (frm_cycles != 0) perf_nonzero = 1;
            if (aw_hold && axi.m_awvalid_o &&
                (axi.m_awaddr_o != hold_addr || axi.m_awlen_o != hold_len)) aw_unstable++;
            aw_hold   = axi.m_awvalid_o && !axi.m_awready_i;
            hold_addr = axi.m_awaddr_o;
            hold_len  = axi.m_awlen_o;
            if (axi.m_awvalid_o && axi.m_awready_i) begin
                aw_addr_q.push_back(axi.m_awaddr_o);
                aw_len_q.push_back(axi.m_awlen_o);
                aw_wait = 0;
            end else if (axi.m_awvalid_o) begin
                aw_wait++;
            end
            if (axi.m_wvalid_o && axi.m_wready_i) begin
                w_data_q.push_back(axi.m_wdata_o);
                w_last_q.push_back(axi.m_wlast_o);
                next_pix++;
                if (axi.m_wlast_o) b_pending = 1;
            end
            if (axi.m_bvalid_i && axi.m_bready_o) begin
                b_cnt++;
                t_b = cyc;
                b_pending = 0;
            end
            @(posedge clk);
            #1;
            axi.m_awready_i = rand_mode ? 1'($urandom_range(0, 1))
                                        : (axi.m_awvalid_o && aw_wait >= aw_delay);
            axi.m_wready_i  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            pxl_vld         = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            pxl_data        = next_pix;
            axi.m_bvalid_i  = b_pending;
            axi.m_bresp_i   = (b_cnt == err_burst) ? 2'b10 : 2'b00;
        end
    end

    task automatic clear_logs();
        aw_addr_q.delete();
        aw_len_q.delete();
        w_data_q.delete();
        w_last_q.delete();
        done_cnt = 0;
        b_cnt = 0;
        aw_unstable = 0;
        next_pix = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        dvp_stat = '0;
        frm_start = 1'b0;
        rand_mode = 0;
        aw_delay = 0;
        err_burst = -1;
        b_pending = 0;
        repeat (3) @(posedge clk);
        #1;
        clear_logs();
        rst_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        dvp_stat = 32'h1;
        base = 32'h8000_0010;
        wait_cycles(3);
        frm_start = 1'b1;
        wait_cycles(1);
        frm_start = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        wait_cycles(3);
        checks++;
        if (done_cnt < target) begin
            failures++;
            $display("FAIL %s timeout: frm_done count %0d, required %0d", name, done_cnt, target);
        end
    endtask

    function automatic int data_errs(input logic [31:0] first);
        int e = 0;
        if (w_data_q.size() != FW) return FW;
        for (int i = 0; i < FW; i++)
            if (w_data_q[i] !== first + 32'(i)) e++;
        return e;
    endfunction

    function automatic int last_errs();
        int e = 0;
        if (w_last_q.size() != FW) return FW;
        for (int i = 0; i < FW; i++)
            if (w_last_q[i] !== (i == 15 || i == 31 || i == 39)) e++;
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(2);
        checks++;
        if ({pxl_rdy, axi.m_awvalid_o, axi.m_wvalid_o, axi.m_wlast_o, axi.m_bready_o,
             frm_done, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctl: got %b required 0000000", {pxl_rdy, axi.m_awvalid_o,
                     axi.m_wvalid_o, axi.m_wlast_o, axi.m_bready_o, frm_done, err});
        end
        checks++;
        if (axi.m_awaddr_o !== 32'h0 || axi.m_awlen_o !== 8'h0 || axi.m_wdata_o !== 32'h0 ||
            axi.m_awid_o !== 5'h0 || frm_cycles !== 32'h0) begin
            failures++;
            $display("FAIL reset_bus: addr %h len %h wdata %h id %h cyc %h required all 0",
                     axi.m_awaddr_o, axi.m_awlen_o, axi.m_wdata_o, axi.m_awid_o, frm_cycles);
        end
        checks++;
        if (dut.state !== 3'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d required 0", dut.state);
        end
    endtask

    task automatic test_basic();
        do_reset();
        start_frame();
        checks++;
        if (axi.m_awvalid_o !== 1'b1 || axi.m_awaddr_o !== 32'h8000_0000) begin
            failures++;
            $display("FAIL basic_aw_latency: awvalid %b addr %h required 1 80000000",
                     axi.m_awvalid_o, axi.m_awaddr_o);
        end
        wait_done(1, "basic_done");
        checks++;
        if (aw_addr_q.size() != 3 || aw_addr_q[0] !== 32'h8000_0000 ||
            aw_addr_q[1] !== 32'h8000_0040 || aw_addr_q[2] !== 32'h8000_0080) begin
            failures++;
            $display("FAIL basic_awaddr: count %0d required 3 (80000000/40/80)", aw_addr_q.size());
        end
        checks++;
        if (aw_len_q.size() != 3 || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd15 ||
            aw_len_q[2] !== 8'd7) begin
            failures++;
            $display("FAIL basic_awlen: count %0d required 3 (15/15/7)", aw_len_q.size());
        end
        checks++;
        if (last_errs() != 0) begin
            failures++;
            $display("FAIL basic_wlast: %0d bad beats required 0", last_errs());
        end
        checks++;
        if (data_errs(0) != 0) begin
            failures++;
            $display("FAIL basic_data: %0d bad beats required 0", data_errs(0));
        end
        checks++;
        if (done_cnt != 1 || err !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_err: done %0d err %b required 1 0", done_cnt, err);
        end
    endtask

    task automatic test_random();
        do_reset();
        rand_mode = 1;
        start_frame();
        wait_done(1, "random_done");
        checks++;
        if (data_errs(0) != 0) begin
            failures++;
            $display("FAIL random_data: %0d bad beats (count %0d) required 0", data_errs(0),
                     w_data_q.size());
        end
        checks++;
        if (aw_unstable != 0) begin
            failures++;
            $display("FAIL random_aw_stable: %0d changes required 0", aw_unstable);
        end
        checks++;
        if (aw_len_q.size() != 3 || aw_addr_q[2] !== 32'h8000_0080 || aw_len_q[2] !== 8'd7) begin
            failures++;
            $display("FAIL random_aw: count %0d required 3", aw_len_q.size());
        end
        rand_mode = 0;
    endtask

    task automatic test_err();
        int n = 0;
        do_reset();
        err_burst = 1;
        start_frame();
        while (b_cnt < 2 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        wait_cycles(1);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set: got %b required 1", err);
        end
        wait_done(1, "err_done");
        checks++;
        if (err !== 1'b1 || aw_addr_q.size() != 3) begin
            failures++;
            $display("FAIL err_sticky: err %b bursts %0d required 1 3", err, aw_addr_q.size());
        end
        dvp_stat = 32'h0;
        wait_cycles(3);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear: got %b required 0", err);
        end
    endtask

    task automatic test_en_drop();
        int n = 0;
        do_reset();
        start_frame();
        while (w_data_q.size() < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        dvp_stat = 32'h0;
        wait_cycles(60);
        checks++;
        if (aw_addr_q.size() != 2 || w_data_q.size() != 32 || b_cnt != 2) begin
            failures++;
            $display("FAIL endrop_counts: aw %0d w %0d b %0d required 2 32 2",
                     aw_addr_q.size(), w_data_q.size(), b_cnt);
        end
        checks++;
        if (w_last_q.size() != 32 || w_last_q[31] !== 1'b1) begin
            failures++;
            $display("FAIL endrop_wlast: beats %0d, last beat without wlast", w_last_q.size());
        end
        checks++;
        if (done_cnt != 0 || dut.state !== 3'd0 || axi.m_awvalid_o !== 1'b0) begin
            failures++;
            $display("FAIL endrop_idle: done %0d state %0d awvalid %b required 0 0 0",
                     done_cnt, dut.state, axi.m_awvalid_o);
        end
    endtask

    task automatic test_restart();
        int n = 0;
        do_reset();
        start_frame();
        while (w_data_q.size() < 5 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        frm_start = 1'b1;
        wait_cycles(1);
        frm_start = 1'b0;
        wait_done(1, "restart_first_done");
        checks++;
        if (aw_addr_q.size() != 3 || data_errs(0) != 0) begin
            failures++;
            $display("FAIL restart_ignored: bursts %0d bad beats %0d required 3 0",
                     aw_addr_q.size(), data_errs(0));
        end
        clear_logs();
        next_pix = 32'd100;
        frm_start = 1'b1;
        wait_cycles(1);
        frm_start = 1'b0;
        wait_done(1, "restart_second_done");
        checks++;
        if (aw_addr_q.size() != 3 || aw_addr_q[0] !== 32'h8000_0000 || data_errs(100) != 0) begin
            failures++;
            $display("FAIL restart_new_frame: bursts %0d bad beats %0d required 3 0",
                     aw_addr_q.size(), data_errs(100));
        end
    endtask

    task automatic test_perf();
        do_reset();
        aw_delay = 2;
        start_frame();
        wait_done(1, "perf_done");
`ifdef DVP_FRAME_DMA_PERF_EN
        checks++;
        if (frm_cycles !== 32'(t_b - t_start)) begin
            failures++;
            $display("FAIL perf_measured: got %0d required %0d", frm_cycles, t_b - t_start);
        end
        checks++;
        if (frm_cycles !== 32'd52) begin
            failures++;
            $display("FAIL perf_const: got %0d required 52", frm_cycles);
        end
`else
        checks++;
        if (frm_cycles !== 32'd0 || perf_nonzero) begin
            failures++;
            $display("FAIL perf_off: got %0d (seen nonzero %0d) required 0", frm_cycles, perf_nonzero);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_err();
        test_en_drop();
        test_restart();
        test_perf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
